uart_tx_buffered: RTL

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_fifo.sv | 64 ++++++
 rtl/uart_tx_buffered.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer/deserializer state encoding and frame bit levels.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_fifo.sv
// Generic synchronous FIFO with occupancy count; head word visible on o_data while non-empty.
// Latency: a push is visible at the head (and in o_level) the cycle after the write edge.
// Backpressure: pushes while full are dropped, even when a pop happens in the same cycle.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_level = r_level;

  // Storage array: written at the tail on an accepted push; contents need no reset.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; level tracks push minus pop.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (!w_push && w_pop) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO of payload words feeding a start/data/stop serializer.
// Latency: push into empty FIFO with idle serializer -> pop next cycle -> start bit on o_tx the cycle after.
// Backpressure: o_full high means further pushes are silently dropped; frames run back to back while queued.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int PAYLOAD_SIZE  = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int TICKS_PER_BIT = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_tick,
  input  logic [PAYLOAD_SIZE-1:0]       i_data,
  input  logic                          i_send_data,
  output logic                          o_tx,
  output logic                          o_flg_data_sent,
  output logic                          o_full,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam int BW = $clog2(PAYLOAD_SIZE) + 1;

  uart_state_t             r_state;
  logic [PAYLOAD_SIZE-1:0] r_shift;
  logic [TW-1:0]           r_tick_cnt;
  logic [BW-1:0]           r_bit_cnt;
  logic                    r_tx;
  logic                    r_flg;

  logic [PAYLOAD_SIZE-1:0] w_head;
  logic [PAYLOAD_SIZE-1:0] w_shift_nxt;
  logic                    w_empty;
  logic                    w_bit_end;
  logic                    w_pop;

  // A bit period closes on the tick that completes TICKS_PER_BIT ticks.
  assign w_bit_end   = i_tick && (r_tick_cnt == TW'(TICKS_PER_BIT - 1));
  assign w_shift_nxt = r_shift >> 1;
  // Pop from IDLE, or straight out of STOP so queued frames follow with no idle gap.
  assign w_pop = !w_empty &&
                 ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));

  uart_fifo #(
    .WIDTH (PAYLOAD_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_send_data),
    .i_data  (i_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (o_full),
    .o_empty (w_empty),
    .o_level (o_level)
  );

  assign o_tx            = r_tx;
  assign o_flg_data_sent = r_flg;
  assign o_busy          = !w_empty || (r_state != ST_IDLE);

  // Serializer FSM; o_tx is set on the same edge as each state/bit change so it is registered.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_tx       <= STOP_BIT;
      r_flg      <= 1'b0;
    end else begin
      r_flg <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tx <= STOP_BIT;
          if (!w_empty) begin
            r_shift    <= w_head;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= START_BIT;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_tick_cnt <= '0;
            r_tx       <= r_shift[0];
            r_state    <= ST_DATA;
          end else if (i_tick) begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_tick_cnt <= '0;
            r_shift    <= w_shift_nxt;
            if (r_bit_cnt == BW'(PAYLOAD_SIZE - 1)) begin
              r_tx    <= STOP_BIT;
              r_state <= ST_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
              r_tx      <= w_shift_nxt[0];
            end
          end else if (i_tick) begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            r_flg      <= 1'b1;
            r_tick_cnt <= '0;
            if (!w_empty) begin
              r_shift   <= w_head;
              r_bit_cnt <= '0;
              r_tx      <= START_BIT;
              r_state   <= ST_START;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (i_tick) begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
